// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// the M-extension funct7 and the sequencing FSM state encoding.
package muldiv_pkg;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Operand sign/magnitude split and divide special-case detection, evaluated
// combinationally on the raw request so IDLE can take the fast path.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] mag_a,
    output logic [XLEN-1:0] mag_b,
    output logic            neg_a,
    output logic            neg_b,
    output logic            special,
    output logic [XLEN-1:0] special_result
);

    logic signed_a;
    logic signed_b;
    logic div_zero;
    logic div_ovf;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        signed_a = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                   (funct3 == F3_DIV)  || (funct3 == F3_REM);
        signed_b = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);

        neg_a = signed_a && operand_a[XLEN-1];
        neg_b = signed_b && operand_b[XLEN-1];
        // The most negative value maps onto itself, which is its correct unsigned magnitude.
        mag_a = neg_a ? -operand_a : operand_a;
        mag_b = neg_b ? -operand_b : operand_b;

        div_zero = funct3[2] && (operand_b == '0);
        div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);

        special        = div_zero || div_ovf;
        special_result = '0;
        if (div_zero)
            special_result = funct3[1] ? operand_a : '1;
        else if (div_ovf)
            special_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// XLEN iterations in CALC, sign correction in FIX, one-cycle done pulse.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic              neg_a_q, neg_b_q;
    logic [XLEN-1:0]   step_operand;   // multiplicand for multiply, divisor for divide
    logic [2*XLEN-1:0] acc;            // product, or dividend/quotient in the low half
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   result_d;

    logic [XLEN-1:0] mag_a, mag_b, special_result;
    logic            neg_a, neg_b, special;

    muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
        .funct3         (funct3),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .mag_a          (mag_a),
        .mag_b          (mag_b),
        .neg_a          (neg_a),
        .neg_b          (neg_b),
        .special        (special),
        .special_result (special_result)
    );

    logic            accept;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_shift;
    logic            rem_ge;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fix_result;

    always_comb begin
        accept    = (state == IDLE) && start;
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, step_operand} : '0);
        rem_shift = {rem, acc[XLEN-1]};
        rem_ge    = rem_shift >= {1'b0, step_operand};

        // Unsigned ops have both sign flags clear, so these collapse to pass-through.
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = neg_a_q ? -rem : rem;

        case (op)
            F3_MUL:                       fix_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_result = quo_fix;
            default:                      fix_result = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state;
        result_d = result;
        case (state)
            IDLE: if (start) begin
                if (special) begin
                    state_d  = DONE;
                    result_d = special_result;
                end else begin
                    state_d = CALC;
                end
            end
            CALC: if (cnt == LAST_ITER) state_d = FIX;
            FIX: begin
                state_d  = DONE;
                result_d = fix_result;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state  <= state_d;
            busy   <= (state_d != IDLE);
            done   <= (state_d == DONE);
            result <= result_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            op           <= F3_MUL;
            neg_a_q      <= 1'b0;
            neg_b_q      <= 1'b0;
            step_operand <= '0;
            acc          <= '0;
            rem          <= '0;
        end else if (accept) begin
            cnt          <= '0;
            op           <= funct3;
            neg_a_q      <= neg_a;
            neg_b_q      <= neg_b;
            step_operand <= funct3[2] ? mag_b : mag_a;
            acc          <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            rem          <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (op[2]) begin
                rem             <= rem_ge ? XLEN'(rem_shift - {1'b0, step_operand})
                                          : rem_shift[XLEN-1:0];
                acc[XLEN-1:0]   <= {acc[XLEN-2:0], rem_ge};
            end else begin
                acc <= {mul_sum, acc[XLEN-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected result and latency are queued at
// issue and popped when done pulses; also covers held start and mid-op reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] operand_a, operand_b;
    logic        busy, done;
    logic [31:0] result;

    int n_vec  = 0;
    int n_bad  = 0;
    int n_done = 0;

    logic [31:0] sb_res[$];
    int          sb_lat[$];

    always #5 clk = ~clk;

    muldiv_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .funct3    (funct3),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp;
        logic [63:0]        ua, ub, up;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        model = '0;
        case (op)
            F3_MUL:    begin up = ua * ub;          model = up[31:0];  end
            F3_MULH:   begin sp = sa * sb;          model = sp[63:32]; end
            F3_MULHSU: begin sp = sa * $signed(ub); model = sp[63:32]; end
            F3_MULHU:  begin up = ua * ub;          model = up[63:32]; end
            F3_DIV:    model = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : $signed(a) / $signed(b);
            F3_DIVU:   model = (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:    model = (b == 0) ? a : ovf ? 32'h0 : $signed(a) % $signed(b);
            default:   model = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0)) return 1;
        if (((op == F3_DIV) || (op == F3_REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 1;
        return 34;
    endfunction

    // Issues one op and waits for its done pulse; hold keeps start high and
    // scrambles the operands mid-CALC, which must not affect the result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit hold);
        int cyc;
        bit busy_ok;
        logic [31:0] exp_r;
        int exp_l;
        int d0;
        @(negedge clk);
        funct3 = op; operand_a = a; operand_b = b; start = 1'b1;
        sb_res.push_back(exp);
        sb_lat.push_back(exp_latency(op, a, b));
        @(posedge clk);
        @(negedge clk);
        if (!hold) start = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && cyc < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (hold && cyc == 10) begin
                operand_a = ~a;
                operand_b = b ^ 32'h5;
            end
            @(negedge clk);
            cyc++;
        end
        exp_r = sb_res.pop_front();
        exp_l = sb_lat.pop_front();
        check({tag, "/done"}, done, 1'b1);
        check({tag, "/latency"}, cyc, exp_l);
        check({tag, "/result"}, result, exp_r);
        check({tag, "/busy"}, {busy_ok, busy}, 2'b11);
        @(negedge clk);
        start = 1'b0;
        #1;
        d0 = n_done;
        check({tag, "/idle"}, {busy, done}, 2'b00);
        if (hold) begin
            repeat (40) @(negedge clk);
            #1;
            check({tag, "/extra_done"}, n_done - d0, 0);
            check({tag, "/held_result"}, result, exp_r);
        end
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        int          d0;

        rst = 1'b1; start = 1'b0; funct3 = '0; operand_a = '0; operand_b = '0;
        #1;
        check("reset", {busy, done, result}, 34'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("mul",     F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op("mulh",    F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
        run_op("mulhu",   F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulhsu",  F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1'b0);
        run_op("div",     F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
        run_op("rem",     F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
        run_op("divu",    F3_DIVU,   32'd100,        32'd7,         32'd14,        1'b0);
        run_op("remu",    F3_REMU,   32'd100,        32'd7,         32'd2,         1'b0);
        run_op("div0",    F3_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0);
        run_op("rem0",    F3_REM,    32'd5,          32'd0,         32'd5,         1'b0);
        run_op("divovf",  F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("removf",  F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b0);
        run_op("hold",    F3_DIV,    32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 4 == 1) rb = rb >> 20;
            if (i % 5 == 0) rb = '0;
            run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b0);
        end

        // Abort a multiply at E+10 with reset; the previous result is nonzero.
        @(negedge clk);
        funct3 = F3_MUL; operand_a = 32'h1234; operand_b = 32'h5678; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("rst/busy_before", busy, 1'b1);
        rst = 1'b1;
        #1;
        check("rst/outputs", {busy, done, result}, 34'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        d0 = n_done;
        repeat (40) @(negedge clk);
        #1;
        check("rst/no_done", n_done - d0, 0);
        check("rst/idle", {busy, result}, 33'h0);

        run_op("after_rst", F3_MUL, 32'h1234, 32'h5678, 32'h0626_0060, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
